or_gate_4input: RTL and testbench
=================================

// Module: or_gate_4input
// PURPOSE
//  Registered 4-input bitwise OR used to merge per-bank/per-core data words before they are
//  forwarded in the memory hierarchy. Each input can be masked out; the result is registered
//  with a valid flag and status flags. One clock, synchronous active-low reset.
// PARAMETERS
//  DATA_WIDTH  32  width of every data input and of result
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           synchronous reset, active low
//  in_valid    in   1           din1..din4 and in_mask are valid this cycle
//  in_mask     in   4           bit i=1 includes din(i+1) in the OR; bit i=0 forces it to zero
//  din1        in   DATA_WIDTH  operand 1
//  din2        in   DATA_WIDTH  operand 2
//  din3        in   DATA_WIDTH  operand 3
//  din4        in   DATA_WIDTH  operand 4
//  result      out  DATA_WIDTH  registered OR of the unmasked operands
//  out_valid   out  1           result updated in this cycle
//  result_zero out  1           registered flag: the captured result is all zeros
//  overlap     out  1           registered flag, present only with OR4_OVERLAP_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: on a rising clk edge with rst_n=0, result=0, out_valid=0, result_zero=1, overlap=0.
//    Reset takes priority over in_valid.
//  - Latency 1 cycle. At the edge where in_valid=1:
//    result <= (din1&{W{m0}})|(din2&{W{m1}})|(din3&{W{m2}})|(din4&{W{m3}}), out_valid <= 1,
//    result_zero <= (that value == 0). Here m0..m3 are in_mask[0..3] and W=DATA_WIDTH.
//  - At an edge where in_valid=0: out_valid <= 0. result, result_zero and overlap hold their values.
//  - Back-to-back in_valid gives one result per cycle. There is no backpressure and no ready signal.
//  - in_mask=4'b0000 with in_valid=1 gives result=0, result_zero=1, out_valid=1.
//  - The OR is purely bitwise. There is no carry or width growth, and every bit is independent.
//  - X on a masked-out input must not propagate: mask with AND before the OR.
// CONFIGURATION
//  - OR4_OVERLAP_CHECK_EN defined:
//    - The overlap port exists.
//    - At each in_valid edge, overlap <= 1 if any bit position is set in two or more unmasked operands.
//  - Not defined: the overlap port and its logic are absent, and the other ports are unchanged.
// STRUCTURE
//  - Shared package or4_pkg:
//    - localparam N_IN=4
//    - default DATA_WIDTH=32
//    - typedef for the mask vector logic [N_IN-1:0]
//  - One sub-module, or_gate_2input: combinational 2-operand masked OR.
//  - Instantiate or_gate_2input as a 2-level tree: (1|2), (3|4), then the final OR.
//  - The overlap check uses a per-bit population test (count of set operands >= 2) in the top level.
// TESTING
//  1. Hold rst_n=0 for 2 cycles, with in_valid=1 and nonzero data.
//     -> result=0, out_valid=0, result_zero=1.
//  2. din1..4=F000/0F00/00F0/000F, mask=1111, in_valid=1.
//     -> next cycle result=0000FFFF, out_valid=1, result_zero=0, overlap=0.
//  3. Same data as scenario 2 with mask=0101.
//     -> result=0000F0F0. Then mask=0000 -> result=0, result_zero=1.
//  4. din1=0000FF00, din2=00000FF0, din3=din4=0, mask=1111.
//     -> result=00000FF0|0000FF00=0000FFF0, overlap=1 (only when the macro is defined).
//  5. Valid pulse followed by in_valid=0 for 3 cycles with changing din.
//     -> result holds its last value, and out_valid is 1 for exactly one cycle.
//  6. Assert rst_n=0 for one edge in the middle of a back-to-back valid stream.
//     -> outputs take reset values at that edge. The stream then resumes with 1-cycle latency.

Source files
------------

// File: rtl/or4_pkg.sv
// Shared definitions for the registered 4-input masked OR (or_gate_4input).
package or4_pkg;
    localparam int N_IN               = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic [N_IN-1:0] mask_t;
endpackage

// File: rtl/or_gate_2input.sv
// Combinational 2-operand masked OR: each operand is ANDed with its mask bit before the OR,
// so an X on a masked-out operand never reaches y.
module or_gate_2input #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  mask_a,
    input  logic                  mask_b,
    output logic [DATA_WIDTH-1:0] y
);
    assign y = (a & {DATA_WIDTH{mask_a}}) | (b & {DATA_WIDTH{mask_b}});
endmodule

// File: rtl/or_gate_4input.sv
// Registered 4-input masked bitwise OR with valid and result-zero flags.
// Optional OR4_OVERLAP_CHECK_EN adds a registered overlap flag (bit set in >=2 unmasked operands).
module or_gate_4input
    import or4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [3:0]            in_mask,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [DATA_WIDTH-1:0] din4,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  out_valid,
`ifdef OR4_OVERLAP_CHECK_EN
    output logic                  overlap,
`endif
    output logic                  result_zero
);
    mask_t                 mask;
    logic [DATA_WIDTH-1:0] or_12;
    logic [DATA_WIDTH-1:0] or_34;
    logic [DATA_WIDTH-1:0] or_all;

    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  out_valid_d, out_valid_q;
    logic                  result_zero_d, result_zero_q;

    assign mask = in_mask;

    // Masking happens at the leaves; the root combines already-masked partials.
    or_gate_2input #(.DATA_WIDTH(DATA_WIDTH)) u_or_12 (
        .a(din1), .b(din2), .mask_a(mask[0]), .mask_b(mask[1]), .y(or_12)
    );
    or_gate_2input #(.DATA_WIDTH(DATA_WIDTH)) u_or_34 (
        .a(din3), .b(din4), .mask_a(mask[2]), .mask_b(mask[3]), .y(or_34)
    );
    or_gate_2input #(.DATA_WIDTH(DATA_WIDTH)) u_or_root (
        .a(or_12), .b(or_34), .mask_a(1'b1), .mask_b(1'b1), .y(or_all)
    );

    always_comb begin
        result_d      = result_q;
        out_valid_d   = 1'b0;
        result_zero_d = result_zero_q;
        if (in_valid) begin
            result_d      = or_all;
            out_valid_d   = 1'b1;
            result_zero_d = (or_all == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q      <= '0;
            out_valid_q   <= 1'b0;
            result_zero_q <= 1'b1;
        end else begin
            result_q      <= result_d;
            out_valid_q   <= out_valid_d;
            result_zero_q <= result_zero_d;
        end
    end

    assign result      = result_q;
    assign out_valid   = out_valid_q;
    assign result_zero = result_zero_q;

`ifdef OR4_OVERLAP_CHECK_EN
    logic [DATA_WIDTH-1:0] m1, m2, m3, m4;
    logic                  overlap_now;
    logic                  overlap_d, overlap_q;

    assign m1 = din1 & {DATA_WIDTH{mask[0]}};
    assign m2 = din2 & {DATA_WIDTH{mask[1]}};
    assign m3 = din3 & {DATA_WIDTH{mask[2]}};
    assign m4 = din4 & {DATA_WIDTH{mask[3]}};

    // Per-bit population count of the unmasked operands; two or more set bits is an overlap.
    always_comb begin
        logic [2:0] cnt;
        overlap_now = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt = {2'b00, m1[i]} + {2'b00, m2[i]} + {2'b00, m3[i]} + {2'b00, m4[i]};
            if (cnt >= 3'd2) overlap_now = 1'b1;
        end
    end

    always_comb begin
        overlap_d = overlap_q;
        if (in_valid) overlap_d = overlap_now;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) overlap_q <= 1'b0;
        else        overlap_q <= overlap_d;
    end

    assign overlap = overlap_q;
`endif
endmodule

// File: tb/tb_or_gate_4input.sv
// Directed self-checking bench for or_gate_4input; overlap checks apply when OR4_OVERLAP_CHECK_EN is defined.
module tb_or_gate_4input;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_mask;
    logic [31:0] din1, din2, din3, din4;
    logic [31:0] result;
    logic        out_valid;
    logic        result_zero;
`ifdef OR4_OVERLAP_CHECK_EN
    logic        overlap;
`endif

    int nvec = 0;
    int nerr = 0;

    or_gate_4input #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mask(in_mask),
        .din1(din1), .din2(din2), .din3(din3), .din4(din4),
        .result(result), .out_valid(out_valid),
`ifdef OR4_OVERLAP_CHECK_EN
        .overlap(overlap),
`endif
        .result_zero(result_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r, input logic v,
                           input logic z, input logic ov);
        chk({tag, ".result"}, result, r);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".result_zero"}, {31'd0, result_zero}, {31'd0, z});
`ifdef OR4_OVERLAP_CHECK_EN
        chk({tag, ".overlap"}, {31'd0, overlap}, {31'd0, ov});
`else
        if (ov === 1'bx) $display("unexpected x flag in %s", tag);
`endif
    endtask

    task automatic drive(input logic v, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        in_valid = v; in_mask = m; din1 = a; din2 = b; din3 = c; din4 = d;
    endtask

    initial begin
        // 1: reset dominates in_valid
        #1;
        rst_n = 1'b0;
        drive(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3);
        tick(); tick();
        chk_out("reset", 32'h0, 1'b0, 1'b1, 1'b0);

        // 2: disjoint nibbles, all unmasked
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 32'h0000_F000, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_000F);
        tick();
        chk_out("all_mask", 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);

        // 3: partial mask, then empty mask
        in_mask = 4'b0101;
        tick();
        chk_out("mask0101", 32'h0000_F0F0, 1'b1, 1'b0, 1'b0);
        in_mask = 4'b0000;
        tick();
        chk_out("mask0000", 32'h0, 1'b1, 1'b1, 1'b0);

        // 4: overlapping operands
        drive(1'b1, 4'b1111, 32'h0000_FF00, 32'h0000_0FF0, 32'h0, 32'h0);
        tick();
        chk_out("overlap", 32'h0000_FFF0, 1'b1, 1'b0, 1'b1);

        // overlap only counts unmasked operands
        in_mask = 4'b0001;
        tick();
        chk_out("overlap_masked", 32'h0000_FF00, 1'b1, 1'b0, 1'b0);

        // full-width complementary operands, no shared bit
        drive(1'b1, 4'b0011, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk_out("full_width", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // X on masked-out operands must not leak
        drive(1'b1, 4'b0001, 32'h0000_0005, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        tick();
        chk_out("x_masked", 32'h0000_0005, 1'b1, 1'b0, 1'b0);

        // 5: single valid pulse then idle with changing data
        drive(1'b1, 4'b1001, 32'h1234_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_5678);
        tick();
        chk_out("pulse", 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b1111, 32'h1 << i, 32'h1 << i, 32'h0, 32'h0);
            tick();
            chk_out("idle_hold", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        end

        // 6: reset in the middle of a back-to-back stream
        drive(1'b1, 4'b0001, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("stream_a", 32'h1, 1'b1, 1'b0, 1'b0);
        din1 = 32'h0000_0003; din2 = 32'h0000_0002; in_mask = 4'b0011;
        tick();
        chk_out("stream_b", 32'h3, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0; din1 = 32'h0000_0004; in_mask = 4'b0001;
        tick();
        chk_out("stream_rst", 32'h0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1; din1 = 32'h0000_0008;
        tick();
        chk_out("stream_resume", 32'h8, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_out("stream_end", 32'h8, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
